// File: rtl/debounce_pkg.sv
// Shared state encoding and default timing constants for the button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; clears with the synchronous reset.
module sync_ff
    import debounce_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_pulse_debouncer.sv
// Synchronises and debounces a push-button, emitting one pulse per accepted press.
// Define AUTOREPEAT_EN to add auto-repeat pulses while the button is held.
module button_pulse_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse_out,
    output logic btn_level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_param_check
        $error("button_pulse_debouncer: illegal parameter value");
    end

    logic      b;
    logic      s;
    db_state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d, count_inc;
    logic      count_full;
    logic      accept;
    logic      rep_fire;
    logic      pulse_q, pulse_d;
    logic      level_q, level_d;

    assign b = btn_in ^ ACTIVE_LOW;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (b),
        .q  (s)
    );

    assign count_full = (count_q == CW'(DEBOUNCE_CYCLES));
    assign count_inc  = count_full ? count_q : count_q + 1'b1;

`ifdef AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_phase_q, rep_phase_d;  // 0: waiting initial delay, 1: periodic
    logic [REP_W-1:0] rep_limit;

    assign rep_limit = rep_phase_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);

    // Timer only runs while staying in HELD; any other path restarts it in the delay phase.
    always_comb begin
        rep_d       = '0;
        rep_phase_d = 1'b0;
        rep_fire    = 1'b0;
        if (state_q == HELD && s) begin
            if (rep_q == rep_limit) begin
                rep_fire    = 1'b1;
                rep_phase_d = 1'b1;
            end else begin
                rep_d       = rep_q + 1'b1;
                rep_phase_d = rep_phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q       <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    count_d = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_full) begin
                    state_d = HELD;
                    count_d = '0;
                    accept  = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    count_d = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    count_d = '0;
                end else if (count_full) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_inc;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        pulse_d = accept | rep_fire;
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    assign pulse_out = pulse_q;
    assign btn_level = level_q;

endmodule

// File: tb/tb_button_pulse_debouncer.sv
// Directed self-checking bench for button_pulse_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
module tb_button_pulse_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic pulse_out;
    logic btn_level;

    int errors = 0;
    int checks = 0;
    int pulse_total = 0;
    int double_pulses = 0;
    logic prev_pulse = 1'b0;

    button_pulse_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .ACTIVE_LOW     (1'b0),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .pulse_out(pulse_out),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (pulse_out === 1'b1) pulse_total++;
        if (pulse_out === 1'b1 && prev_pulse === 1'b1) double_pulses++;
        prev_pulse = pulse_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_in = 1'b0;
        tick();
        tick();
        checks++;
        if (pulse_out !== 1'b0) begin
            errors++;
            $display("FAIL reset pulse_out: got %b want 0", pulse_out);
        end
        checks++;
        if (btn_level !== 1'b0) begin
            errors++;
            $display("FAIL reset btn_level: got %b want 0", btn_level);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (btn_level !== 1'b0 || pulse_total != 0) begin
            errors++;
            $display("FAIL idle_after_reset: level=%b pulses=%0d want 0/0", btn_level, pulse_total);
        end
    endtask

    // Button rises before edge 1; pulse expected only after edge 7, then clean release.
    task automatic test_clean_press();
        int base;
        base = pulse_total;
        btn_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (pulse_out !== (i == 7)) begin
                errors++;
                $display("FAIL clean_press pulse edge %0d: got %b want %b", i, pulse_out, i == 7);
            end
            checks++;
            if (btn_level !== (i >= 7)) begin
                errors++;
                $display("FAIL clean_press level edge %0d: got %b want %b", i, btn_level, i >= 7);
            end
        end
        btn_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (btn_level !== (i < 7) || pulse_out !== 1'b0) begin
                errors++;
                $display("FAIL clean_release edge %0d: level=%b pulse=%b want %b/0",
                         i, btn_level, pulse_out, i < 7);
            end
        end
        checks++;
        if (pulse_total - base != 1) begin
            errors++;
            $display("FAIL clean_press count: got %0d want 1", pulse_total - base);
        end
    endtask

    // High 3 edges, low 1, then held: single pulse after edge 11.
    task automatic test_press_bounce();
        int base;
        base = pulse_total;
        for (int i = 1; i <= 14; i++) begin
            btn_in = (i != 4);
            tick();
            checks++;
            if (pulse_out !== (i == 11) || btn_level !== (i >= 11)) begin
                errors++;
                $display("FAIL press_bounce edge %0d: pulse=%b level=%b want %b/%b",
                         i, pulse_out, btn_level, i == 11, i >= 11);
            end
        end
        checks++;
        if (pulse_total - base != 1) begin
            errors++;
            $display("FAIL press_bounce count: got %0d want 1", pulse_total - base);
        end
    endtask

    // From HELD: low 2 edges, high 1, then low: level falls after edge 10, no pulses.
    task automatic test_release_bounce();
        int base;
        base = pulse_total;
        for (int i = 1; i <= 14; i++) begin
            btn_in = (i == 3);
            tick();
            checks++;
            if (btn_level !== (i < 10) || pulse_out !== 1'b0) begin
                errors++;
                $display("FAIL release_bounce edge %0d: level=%b pulse=%b want %b/0",
                         i, btn_level, pulse_out, i < 10);
            end
        end
        checks++;
        if (pulse_total != base) begin
            errors++;
            $display("FAIL release_bounce count: got %0d want 0", pulse_total - base);
        end
    endtask

    // Reset sampled at edge 4 of a held press: pulse moves from edge 7 to edge 11.
    task automatic test_reset_mid_press();
        int base;
        base = pulse_total;
        btn_in = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            rst = (i == 4);
            tick();
            checks++;
            if (pulse_out !== (i == 11) || btn_level !== (i >= 11)) begin
                errors++;
                $display("FAIL reset_mid_press edge %0d: pulse=%b level=%b want %b/%b",
                         i, pulse_out, btn_level, i == 11, i >= 11);
            end
        end
        rst = 1'b0;
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (btn_level !== 1'b0 || pulse_total - base != 1) begin
            errors++;
            $display("FAIL reset_mid_press end: level=%b pulses=%0d want 0/1",
                     btn_level, pulse_total - base);
        end
    endtask

    // 4-bit counter fed by pulse_out: 5 presses give 5, 11 more wrap to 0.
    task automatic test_counter();
        int base;
        logic [3:0] count;
        base = pulse_total;
        for (int p = 0; p < 5; p++) begin
            btn_in = 1'b1;
            for (int i = 0; i < 10; i++) tick();
            btn_in = 1'b0;
            for (int i = 0; i < 10; i++) tick();
        end
        count = 4'(pulse_total - base);
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL counter_5: got %0d want 5", count);
        end
        for (int p = 0; p < 11; p++) begin
            btn_in = 1'b1;
            for (int i = 0; i < 10; i++) tick();
            btn_in = 1'b0;
            for (int i = 0; i < 10; i++) tick();
        end
        count = 4'(pulse_total - base);
        checks++;
        if (count !== 4'd0 || pulse_total - base != 16) begin
            errors++;
            $display("FAIL counter_wrap: got %0d (raw %0d) want 0 (raw 16)",
                     count, pulse_total - base);
        end
    endtask

    // Hold for 40 cycles past the first pulse (edge 7), then release.
    task automatic test_autorepeat();
        logic exp;
        for (int i = 1; i <= 47; i++) begin
            btn_in = 1'b1;
            tick();
`ifdef AUTOREPEAT_EN
            exp = (i == 7) || (i >= 17 && ((i - 17) % 5) == 0);
`else
            exp = (i == 7);
`endif
            checks++;
            if (pulse_out !== exp) begin
                errors++;
                $display("FAIL autorepeat pulse edge %0d: got %b want %b", i, pulse_out, exp);
            end
        end
        for (int i = 48; i <= 67; i++) begin
            btn_in = 1'b0;
            tick();
            checks++;
            if (pulse_out !== 1'b0) begin
                errors++;
                $display("FAIL autorepeat release edge %0d: got %b want 0", i, pulse_out);
            end
        end
        checks++;
        if (btn_level !== 1'b0) begin
            errors++;
            $display("FAIL autorepeat end level: got %b want 0", btn_level);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_reset_mid_press();
        test_counter();
        test_autorepeat();
        checks++;
        if (double_pulses != 0) begin
            errors++;
            $display("FAIL back_to_back pulses: got %0d want 0", double_pulses);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
